// File: rtl/sd_sector_arbiter.sv
// Two-client sector arbiter in front of sd_controller: round-robin grant, one 512-byte sector per grant.
// Define SD_TIMEOUT_EN to compile in the watchdog that aborts a stalled transfer with err.
module sd_sector_arbiter #(
  parameter int NUM_BYTES      = 512,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_ready,
  input  logic        sd_byte_available,
  input  logic        sd_ready_for_next_byte,
  input  logic [7:0]  sd_dout,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [31:0] sd_addr,
  output logic [7:0]  sd_din,
  input  logic        c0_req,
  input  logic        c1_req,
  input  logic        c0_we,
  input  logic        c1_we,
  input  logic [22:0] c0_sector,
  input  logic [22:0] c1_sector,
  input  logic [7:0]  c0_wdata,
  input  logic [7:0]  c1_wdata,
  output logic        c0_ack,
  output logic        c1_ack,
  output logic        c0_rvalid,
  output logic        c1_rvalid,
  output logic        c0_wnext,
  output logic        c1_wnext,
  output logic        c0_done,
  output logic        c1_done,
  output logic        c0_err,
  output logic        c1_err,
  output logic [7:0]  rdata,
  output logic        busy
);

  localparam int CW = $clog2(NUM_BYTES) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(NUM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_BUSY  = 3'd2,
    S_XFER       = 3'd3,
    S_WAIT_READY = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          grant_r;
  logic          last_grant_r;
  logic          we_r;
  logic [1:0]    ack_r;
  logic [1:0]    rvalid_r;
  logic [1:0]    wnext_r;
  logic [1:0]    done_r;

  logic          pick_s;
  logic          pick_we_s;
  logic [22:0]   pick_sector_s;
  logic          strobe_s;

`ifdef SD_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYCLES - 1);
  logic [WDW-1:0] wd_r;
  logic [1:0]     err_r;
`endif

  // Round-robin pick (the loser of the last transfer wins a tie) and the active byte strobe
  always_comb begin
    pick_s        = 1'b0;
    pick_we_s     = c0_we;
    pick_sector_s = c0_sector;
    strobe_s      = 1'b0;
    if (c0_req && c1_req) begin
      pick_s = ~last_grant_r;
    end else if (c1_req) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    if (pick_s) begin
      pick_we_s     = c1_we;
      pick_sector_s = c1_sector;
    end else begin
      pick_we_s     = c0_we;
      pick_sector_s = c0_sector;
    end
    if (we_r) begin
      strobe_s = sd_ready_for_next_byte;
    end else begin
      strobe_s = sd_byte_available;
    end
  end

  // Transfer sequencer with registered command and per-client pulse outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      cnt_r        <= '0;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      we_r         <= 1'b0;
      sd_rd        <= 1'b0;
      sd_wr        <= 1'b0;
      sd_addr      <= 32'd0;
      rdata        <= 8'd0;
      ack_r        <= 2'b00;
      rvalid_r     <= 2'b00;
      wnext_r      <= 2'b00;
      done_r       <= 2'b00;
`ifdef SD_TIMEOUT_EN
      wd_r         <= '0;
      err_r        <= 2'b00;
`endif
    end else begin
      ack_r    <= 2'b00;
      rvalid_r <= 2'b00;
      wnext_r  <= 2'b00;
      done_r   <= 2'b00;
`ifdef SD_TIMEOUT_EN
      err_r    <= 2'b00;
`endif
      case (state_r)
        S_IDLE: begin
          if (sd_ready && (c0_req || c1_req)) begin
            grant_r        <= pick_s;
            we_r           <= pick_we_s;
            sd_addr        <= {pick_sector_s, 9'd0};
            sd_rd          <= ~pick_we_s;
            sd_wr          <= pick_we_s;
            cnt_r          <= '0;
            ack_r[pick_s]  <= 1'b1;
            state_r        <= S_ISSUE;
          end
        end
        // The controller only drops ready a cycle after it samples the enable
        S_ISSUE: state_r <= S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (!sd_ready) begin
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            state_r <= S_XFER;
          end
        end
        S_XFER: begin
          if (cnt_r == LAST_COUNT) begin
            state_r <= S_WAIT_READY;
          end else if (strobe_s) begin
            cnt_r <= cnt_r + 1'b1;
            if (we_r) begin
              wnext_r[grant_r] <= 1'b1;
            end else begin
              rvalid_r[grant_r] <= 1'b1;
              rdata             <= sd_dout;
            end
          end
        end
        S_WAIT_READY: begin
          if (sd_ready) begin
            done_r[grant_r] <= 1'b1;
            state_r         <= S_DONE;
          end
        end
        S_DONE: begin
          last_grant_r <= grant_r;
          state_r      <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
`ifdef SD_TIMEOUT_EN
      // Watchdog overrides the sequencer when the card stalls
      if (state_r == S_WAIT_BUSY || state_r == S_XFER || state_r == S_WAIT_READY) begin
        if (wd_r == WD_LIMIT) begin
          sd_rd           <= 1'b0;
          sd_wr           <= 1'b0;
          done_r[grant_r] <= 1'b1;
          err_r[grant_r]  <= 1'b1;
          last_grant_r    <= grant_r;
          wd_r            <= '0;
          state_r         <= S_IDLE;
        end else if (strobe_s) begin
          wd_r <= '0;
        end else begin
          wd_r <= wd_r + 1'b1;
        end
      end else begin
        wd_r <= '0;
      end
`endif
    end
  end

  assign sd_din    = grant_r ? c1_wdata : c0_wdata;
  assign busy      = (state_r != S_IDLE);
  assign c0_ack    = ack_r[0];
  assign c1_ack    = ack_r[1];
  assign c0_rvalid = rvalid_r[0];
  assign c1_rvalid = rvalid_r[1];
  assign c0_wnext  = wnext_r[0];
  assign c1_wnext  = wnext_r[1];
  assign c0_done   = done_r[0];
  assign c1_done   = done_r[1];
`ifdef SD_TIMEOUT_EN
  assign c0_err    = err_r[0];
  assign c1_err    = err_r[1];
`else
  assign c0_err    = 1'b0;
  assign c1_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed/randomized bench for sd_sector_arbiter: the bench plays both clients and the SD card,
// and checks grants, byte streams and pulse counts against spec-level expectations.
module tb_sd_sector_arbiter;
  localparam int NB = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        sd_ready, sd_byte_available, sd_ready_for_next_byte;
  logic [7:0]  sd_dout;
  logic        sd_rd, sd_wr;
  logic [31:0] sd_addr;
  logic [7:0]  sd_din;
  logic        c0_req, c1_req, c0_we, c1_we;
  logic [22:0] c0_sector, c1_sector;
  logic [7:0]  c0_wdata, c1_wdata;
  logic        c0_ack, c1_ack, c0_rvalid, c1_rvalid, c0_wnext, c1_wnext;
  logic        c0_done, c1_done, c0_err, c1_err;
  logic [7:0]  rdata;
  logic        busy;

  sd_sector_arbiter dut (
    .clk(clk), .reset(reset), .sd_ready(sd_ready), .sd_byte_available(sd_byte_available),
    .sd_ready_for_next_byte(sd_ready_for_next_byte), .sd_dout(sd_dout), .sd_rd(sd_rd),
    .sd_wr(sd_wr), .sd_addr(sd_addr), .sd_din(sd_din), .c0_req(c0_req), .c1_req(c1_req),
    .c0_we(c0_we), .c1_we(c1_we), .c0_sector(c0_sector), .c1_sector(c1_sector),
    .c0_wdata(c0_wdata), .c1_wdata(c1_wdata), .c0_ack(c0_ack), .c1_ack(c1_ack),
    .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid), .c0_wnext(c0_wnext), .c1_wnext(c1_wnext),
    .c0_done(c0_done), .c1_done(c1_done), .c0_err(c0_err), .c1_err(c1_err),
    .rdata(rdata), .busy(busy)
  );

  always #20 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int model_last = 1;
  int ack_cnt[2] = '{0, 0};
  int rv_cnt[2]  = '{0, 0};
  int wn_cnt[2]  = '{0, 0};
  int dn_cnt[2]  = '{0, 0};
  int er_cnt[2]  = '{0, 0};
  int dbl_ack    = 0;

  // Pulse tally, sampled on the falling edge
  always @(negedge clk) begin
    if (c0_ack) ack_cnt[0]++;
    if (c1_ack) ack_cnt[1]++;
    if (c0_rvalid) rv_cnt[0]++;
    if (c1_rvalid) rv_cnt[1]++;
    if (c0_wnext) wn_cnt[0]++;
    if (c1_wnext) wn_cnt[1]++;
    if (c0_done) dn_cnt[0]++;
    if (c1_done) dn_cnt[1]++;
    if (c0_err) er_cnt[0]++;
    if (c1_err) er_cnt[1]++;
    if (c0_ack && c1_ack) dbl_ack++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [12:0] all_outs();
    return {busy, sd_rd, sd_wr, c0_ack, c1_ack, c0_rvalid, c1_rvalid,
            c0_wnext, c1_wnext, c0_done, c1_done, c0_err, c1_err};
  endfunction

  function automatic logic rvalid_of(input int w);
    return (w == 1) ? c1_rvalid : c0_rvalid;
  endfunction

  function automatic logic wnext_of(input int w);
    return (w == 1) ? c1_wnext : c0_wnext;
  endfunction

  task automatic set_req(input int c, input logic v, input logic we, input logic [22:0] sec);
    if (c == 1) begin
      c1_req = v; c1_we = we; c1_sector = sec;
    end else begin
      c0_req = v; c0_we = we; c0_sector = sec;
    end
  endtask

  task automatic set_wdata(input int who, input logic [7:0] v);
    if (who == 1) begin
      c1_wdata = v; c0_wdata = ~v;
    end else begin
      c0_wdata = v; c1_wdata = ~v;
    end
  endtask

  task automatic wait_ack(output int who, output int lat);
    int a0, a1;
    logic got;
    a0 = ack_cnt[0]; a1 = ack_cnt[1]; got = 1'b0; lat = 0;
    for (int k = 0; k < 64 && !got; k++) begin
      tick();
      lat = k + 1;
      got = (ack_cnt[0] != a0) || (ack_cnt[1] != a1);
    end
    check("ack_seen", {31'd0, got}, 32'd1);
    who = (ack_cnt[1] != a1) ? 1 : 0;
  endtask

  // Card model for one accepted request: ready handshake, byte strobes, then completion
  task automatic serve(input int who, input logic we, input logic [22:0] sec,
                       input int n_single, input int hold);
    int r0, w0, d0, e0, oth, oth0, bad, n_tot, n_exp;
    logic got;
    oth  = 1 - who;
    r0   = rv_cnt[who]; w0 = wn_cnt[who]; d0 = dn_cnt[who]; e0 = er_cnt[who];
    oth0 = ack_cnt[oth] + rv_cnt[oth] + wn_cnt[oth] + dn_cnt[oth];
    bad  = 0;
    check("sd_addr", sd_addr, {sec, 9'd0});
    check("enable_at_ack", {30'd0, sd_rd, sd_wr}, we ? 32'd1 : 32'd2);
    tick(); tick();
    check("enable_held", {30'd0, sd_rd, sd_wr}, we ? 32'd1 : 32'd2);
    sd_ready = 1'b0;
    repeat (3) tick();
    check("enable_released", {30'd0, sd_rd, sd_wr}, 32'd0);
    for (int i = 0; i < n_single; i++) begin
      if (we) begin
        set_wdata(who, i[7:0]);
        sd_ready_for_next_byte = 1'b1;
      end else begin
        sd_dout = i[7:0];
        sd_byte_available = 1'b1;
      end
      tick();
      if (i < NB) begin
        if (we) begin
          if (sd_din !== i[7:0] || wnext_of(who) !== 1'b1) bad++;
        end else begin
          if (rdata !== i[7:0] || rvalid_of(who) !== 1'b1) bad++;
        end
      end
      sd_ready_for_next_byte = 1'b0;
      sd_byte_available = 1'b0;
      tick();
    end
    if (hold > 0) begin
      sd_dout = 8'hEE;
      if (we) sd_ready_for_next_byte = 1'b1;
      else sd_byte_available = 1'b1;
      repeat (hold) tick();
      sd_ready_for_next_byte = 1'b0;
      sd_byte_available = 1'b0;
    end
    repeat (3) tick();
    check("busy_before_ready", {31'd0, busy}, 32'd1);
    check("no_early_done", dn_cnt[who] - d0, 32'd0);
    sd_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      tick();
      got = (dn_cnt[who] != d0);
    end
    check("done_seen", {31'd0, got}, 32'd1);
    n_tot = n_single + hold;
    n_exp = (n_tot > NB) ? NB : n_tot;
    check("byte_data", bad, 32'd0);
    check("rvalid_count", rv_cnt[who] - r0, we ? 32'd0 : n_exp);
    check("wnext_count", wn_cnt[who] - w0, we ? n_exp : 32'd0);
    check("err_clear", er_cnt[who] - e0, 32'd0);
    tick();
    check("done_once", dn_cnt[who] - d0, 32'd1);
    check("other_quiet", ack_cnt[oth] + rv_cnt[oth] + wn_cnt[oth] + dn_cnt[oth] - oth0, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
    model_last = who;
  endtask

  initial begin
    int who, lat, exp_who, d0, e0;
    logic [22:0] sec_a, sec_b;
    reset = 1'b1; sd_ready = 1'b1; sd_byte_available = 1'b0; sd_ready_for_next_byte = 1'b0;
    sd_dout = 8'd0; c0_req = 1'b0; c1_req = 1'b0; c0_we = 1'b0; c1_we = 1'b0;
    c0_sector = 23'd0; c1_sector = 23'd0; c0_wdata = 8'd0; c1_wdata = 8'd0;
    tick(); tick();
    check("reset_outs", {19'd0, all_outs()}, 32'd0);
    check("reset_addr", sd_addr, 32'd0);
    check("reset_rdata", {24'd0, rdata}, 32'd0);
    reset = 1'b0;
    tick();

    // No ack while the card is not ready, then one-cycle acceptance latency
    sd_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 23'd5);
    repeat (3) tick();
    check("no_ack_not_ready", ack_cnt[0] + ack_cnt[1], 32'd0);
    sd_ready = 1'b1;
    wait_ack(who, lat);
    check("ack_latency", lat, 32'd1);
    check("c0_first", who, 32'd0);
    check("sd_addr_sector5", sd_addr, 32'h0000_0A00);
    set_req(0, 1'b0, 1'b0, 23'd5);
    serve(0, 1'b0, 23'd5, NB, 0);

    // c1 write of the top sector, byte 0 presented before the request
    set_wdata(1, 8'd0);
    set_req(1, 1'b1, 1'b1, 23'h7FFFFF);
    wait_ack(who, lat);
    check("c1_write_grant", who, 32'd1);
    check("sd_addr_top", sd_addr, 32'hFFFF_FE00);
    set_req(1, 1'b0, 1'b1, 23'h7FFFFF);
    serve(1, 1'b1, 23'h7FFFFF, NB, 0);

    // 515 strobes, the last ones as one held level: only 512 bytes delivered
    sec_a = 23'($urandom_range(0, 23'h7FFFFF));
    set_req(0, 1'b1, 1'b0, sec_a);
    wait_ack(who, lat);
    check("overflow_grant", who, 32'd0);
    set_req(0, 1'b0, 1'b0, sec_a);
    serve(0, 1'b0, sec_a, NB - 2, 5);

    // Reset part-way through a read: everything clears at once, no done
    set_req(0, 1'b1, 1'b0, 23'd3);
    wait_ack(who, lat);
    set_req(0, 1'b0, 1'b0, 23'd3);
    d0 = dn_cnt[0];
    tick(); tick();
    sd_ready = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 200; i++) begin
      sd_dout = 8'(i + 1);
      sd_byte_available = 1'b1;
      tick();
      sd_byte_available = 1'b0;
      tick();
    end
    check("rdata_before_reset", {24'd0, rdata}, 32'd200);
    reset = 1'b1;
    #2;
    check("async_reset_outs", {19'd0, all_outs()}, 32'd0);
    check("async_reset_addr", sd_addr, 32'd0);
    check("async_reset_rdata", {24'd0, rdata}, 32'd0);
    sd_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("no_done_after_reset", dn_cnt[0] - d0, 32'd0);
    model_last = 1;
    sec_b = 23'($urandom_range(0, 23'h7FFFFF));
    set_wdata(1, 8'd0);
    set_req(1, 1'b1, 1'b1, sec_b);
    wait_ack(who, lat);
    check("post_reset_c1", who, 32'd1);
    set_req(1, 1'b0, 1'b1, sec_b);
    serve(1, 1'b1, sec_b, NB, 0);

    // Reset restores c0 priority on a tie; held requests then alternate
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_last = 1;
    tick();
    set_req(0, 1'b1, 1'b0, 23'd10);
    set_req(1, 1'b1, 1'b0, 23'd11);
    for (int t = 0; t < 4; t++) begin
      wait_ack(who, lat);
      exp_who = 1 - model_last;
      check("rr_grant", who, exp_who);
      set_req(who, 1'b0, 1'b0, (who == 1) ? 23'd11 : 23'd10);
      serve(who, 1'b0, (who == 1) ? 23'd11 : 23'd10, NB, 0);
      set_req(who, 1'b1, 1'b0, (who == 1) ? 23'd11 : 23'd10);
    end
    c0_req = 1'b0;
    c1_req = 1'b0;
    tick();
    check("never_double_ack", dbl_ack, 32'd0);

    // Card stuck busy: no watchdog in the default build, the block just waits
    set_req(0, 1'b1, 1'b0, 23'd7);
    wait_ack(who, lat);
    set_req(0, 1'b0, 1'b0, 23'd7);
    d0 = dn_cnt[0]; e0 = er_cnt[0];
    tick(); tick();
    sd_ready = 1'b0;
    repeat (1100) tick();
    check("stuck_busy", {31'd0, busy}, 32'd1);
    check("stuck_no_done", dn_cnt[0] - d0, 32'd0);
    check("stuck_no_err", er_cnt[0] - e0, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sd_ready = 1'b1;
    tick();
    check("recovered_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
